fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage sitting directly upstream of the execute stage.
- Fetches word-addressed instructions from an instruction memory over a req/ack handshake and buffers up to DEPTH of them, each with its PC.
- Presents the head entry to execute.
- On a taken branch or jump (execute's nextpc differs from pc+1), the controller pulses `redirect`: the queue flushes and fetching restarts at the new PC.

Parameters:
- DEPTH, 4: queue entries; must be a power of two, at least 2.
- AW, 8: instruction memory address width; `imem_addr` is the low AW bits of the fetch PC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstd  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until `imem_ack`.
- imem_addr  out  AW  word address of the request; stable while `imem_req` is high.
- imem_ack  in  1  one-cycle pulse; `imem_data` is valid in the same cycle.
- imem_data  in  32  instruction word.
- deq  in  1  execute consumes the head entry this cycle.
- redirect  in  1  flush and restart fetching.
- redirect_pc  in  32  new fetch PC, valid when `redirect` is high.
- ins  out  32  head instruction; 32'h0 when empty.
- ins_pc  out  32  PC of the head instruction; 32'h0 when empty.
- ins_valid  out  1  queue is non-empty.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rstd=1 at a clk edge):
  - fetch_pc=0, read/write pointers=0, count=0, state=IDLE.
  - imem_req=0, ins_valid=0, ins=0, ins_pc=0.
  - Reset takes priority over all other inputs, including mid-request. After reset, an `imem_ack` arriving for a pre-reset request is ignored: no push, no state change.
- Storage: circular buffer of {pc[31:0], ins[31:0]} entries.
- Outputs are combinational from the head entry (zero when count==0) and registered state only; no combinational path from imem inputs to outputs.
- FSM states: IDLE, WAIT, SQUASH.
- IDLE:
  - imem_req=0.
  - If !redirect and count<DEPTH: go to WAIT.
  - Else stay in IDLE.
  - The request appears the cycle after the decision, with imem_addr=fetch_pc[AW-1:0].
- WAIT:
  - imem_req=1, imem_addr=fetch_pc[AW-1:0].
  - On imem_ack without redirect: push {fetch_pc, imem_data}; fetch_pc<=fetch_pc+1 (32-bit wrap, 32'hFFFFFFFF -> 0).
  - Then: if post-update count<DEPTH, stay in WAIT (back-to-back request at the next PC); otherwise go to IDLE.
- SQUASH:
  - imem_req=1, imem_addr=the stale address latched at the time of the redirect.
  - On imem_ack: discard the data, go to IDLE.
- Redirect (highest priority after reset):
  - count<=0, pointers<=0, fetch_pc<=redirect_pc.
  - `deq` in the same cycle is ignored.
  - From WAIT with no ack this cycle: go to SQUASH.
  - From WAIT with ack this cycle: drop the data, go to IDLE.
  - From SQUASH: update fetch_pc; stay in SQUASH, or go to IDLE if ack arrives.
  - From IDLE: stay in IDLE.
  - First post-redirect instruction: ins_valid no earlier than 3 cycles after redirect with zero-wait memory.
- Dequeue:
  - deq with count==0 is ignored.
  - deq and push in the same cycle: count unchanged; the new entry goes to the tail.
  - The flow-control rule (request only while count<DEPTH, at most one request outstanding) guarantees a push never targets a full queue. An assertion must flag any push at count==DEPTH.
- Latency: with 1-cycle ack, a steady stream delivers 1 instruction per cycle while execute keeps pace.
- Pointer wrap: modulo DEPTH, natural overflow of $clog2(DEPTH)-bit pointers.

Decomposition:
- Shared package `cpu_pkg`:
  - FSM state encoding constants FQ_IDLE/FQ_WAIT/FQ_SQUASH (2-bit).
  - INS_W=32, PC_W=32.
- One natural sub-module: `fq_buffer`, the circular storage with push/pop/flush, count and head read-out.
- The FSM and fetch_pc register live in `fetch_queue`.

Test Plan:
- Reset then stream, memory returning ins_mem[a]=a+100 with ack 1 cycle after req, deq held 0 -> pcs 0..3 fetched; count reaches 4; imem_req drops; ins=100, ins_pc=0.
- Continue with deq=1 every cycle -> ins_pc increments 0,1,2,… each cycle after warm-up; count stays ≤4; no push at count==4.
- Redirect to 32'h40 while in WAIT, ack 2 cycles later with data X -> X never appears; count=0 immediately; next request at addr 8'h40; ins_pc=32'h40, ins=32'h40+100.
- Redirect in the same cycle as ack and deq with count=2 -> queue empty next cycle; acked data dropped; next imem_addr=low AW bits of redirect_pc.
- deq at count==0 plus simultaneous push/pop at count==2 -> count stays 0 in the first case and stays 2 in the second; order preserved.
- rstd=1 asserted mid-WAIT with count=3 -> next cycle: count=0, imem_req=0, ins_valid=0, ins=0; the fetch restarts at pc 0 once rstd deasserts.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: queue FSM states and the
// layout of one buffered instruction entry.
package cpu_pkg;

  localparam int INS_W = 32;
  localparam int PC_W  = 32;

  typedef enum logic [1:0] {
    FQ_IDLE   = 2'd0,
    FQ_WAIT   = 2'd1,
    FQ_SQUASH = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } fq_entry_t;

endpackage

// File: rtl/fq_buffer.sv
// Circular store of {pc, ins} entries with push, pop and flush.
// The head is read out combinationally and forced to zero when empty.
module fq_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstd,
  input  logic                    flush,
  input  logic                    push,
  input  logic [PC_W-1:0]         push_pc,
  input  logic [INS_W-1:0]        push_ins,
  input  logic                    pop,
  output logic [PC_W-1:0]         head_pc,
  output logic [INS_W-1:0]        head_ins,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop on an empty queue is dropped so count can never underflow.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk) begin
    if (rstd || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rstd) begin
      mem[wr_ptr].pc  <= push_pc;
      mem[wr_ptr].ins <= push_ins;
    end
  end

  assign head_pc  = (count != '0) ? mem[rd_ptr].pc  : '0;
  assign head_ins = (count != '0) ? mem[rd_ptr].ins : '0;

  // Upstream flow control only requests with room left, so this must never fire.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rstd) do_push |-> (count != CW'(DEPTH))
  );

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a req/ack port,
// buffers them with their PCs and flushes/restarts on a redirect.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rstd,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_data,
  input  logic                   deq,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            ins,
  output logic [31:0]            ins_pc,
  output logic                   ins_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_state_t       state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] fetch_pc_inc;
  logic            push;
  logic            pop;
  logic            pop_eff;
  logic [CW-1:0]   next_count;

  assign fetch_pc_inc = fetch_pc + 32'd1;
  assign push         = (state == FQ_WAIT) && imem_ack && !redirect;
  assign pop          = deq && !redirect;
  assign pop_eff      = pop && (count != '0);
  assign next_count   = count + CW'(push) - CW'(pop_eff);

  fq_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk      (clk),
    .rstd     (rstd),
    .flush    (redirect),
    .push     (push),
    .push_pc  (fetch_pc),
    .push_ins (imem_data),
    .pop      (pop),
    .head_pc  (ins_pc),
    .head_ins (ins),
    .count    (count)
  );

  assign ins_valid = (count != '0);

  // imem_addr is only reloaded when a fresh request starts, so an outstanding
  // request cut short by a redirect keeps its stale address during SQUASH.
  always_ff @(posedge clk) begin
    if (rstd) begin
      state     <= FQ_IDLE;
      fetch_pc  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      if ((state == FQ_WAIT || state == FQ_SQUASH) && !imem_ack) begin
        state    <= FQ_SQUASH;
        imem_req <= 1'b1;
      end else begin
        state    <= FQ_IDLE;
        imem_req <= 1'b0;
      end
    end else begin
      case (state)
        FQ_IDLE: begin
          if (count < FULL) begin
            state     <= FQ_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc[AW-1:0];
          end
        end
        FQ_WAIT: begin
          if (imem_ack) begin
            fetch_pc <= fetch_pc_inc;
            if (next_count < FULL) begin
              imem_addr <= fetch_pc_inc[AW-1:0];
            end else begin
              state    <= FQ_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        FQ_SQUASH: begin
          if (imem_ack) begin
            state    <= FQ_IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= FQ_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver predicts queue contents from
// the observed handshake, a negedge monitor checks every dequeued head.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rstd = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        deq = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rstd        (rstd),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .deq         (deq),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .count       (count)
  );

  int          tests = 0;
  int          fails = 0;
  int          pops = 0;
  logic [63:0] sb [$];
  logic [63:0] mon_exp;

  // Reference state: queue occupancy, next PC to fetch, pending stale request.
  int          model_count = 0;
  logic [31:0] model_pc = 32'h0;
  bit          stale = 1'b0;
  logic [7:0]  stale_addr = 8'h0;

  function automatic logic [31:0] memWord(input logic [7:0] a);
    return {24'h0, a} + 32'd100;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name, input string got, input string want);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %s, expected %s", name, got, want);
  endtask

  task automatic checkOutput();
    checkVal("count", 32'(count), 32'(model_count));
    checkVal("ins_valid", 32'(ins_valid), 32'(model_count != 0));
    if (model_count == 0) begin
      checkVal("ins_empty", ins, 32'h0);
      checkVal("ins_pc_empty", ins_pc, 32'h0);
    end
    if (model_count == DEPTH) checkVal("req_when_full", 32'(imem_req), 32'h0);
    if (imem_req === 1'b1) checkVal("imem_addr", 32'(imem_addr), 32'(stale ? stale_addr : model_pc[7:0]));
  endtask

  // ack_mode: 0 none, 1 ack whenever requested, 2 always, 3 random
  task automatic applyStimulus(input bit rst, input int ack_mode, input bit d, input bit r,
                               input logic [31:0] rpc);
    bit a;
    bit req_now;
    bit pop_ok;
    @(posedge clk);
    #2;
    checkOutput();
    req_now = (imem_req === 1'b1);
    case (ack_mode)
      0: a = 1'b0;
      1: a = req_now;
      2: a = 1'b1;
      default: a = req_now ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
    endcase
    rstd        = rst;
    imem_ack    = a;
    deq         = d;
    redirect    = r;
    redirect_pc = rpc;
    imem_data   = (req_now && stale) ? 32'hBAD0_0000 : memWord(imem_addr);
    if (rst) begin
      model_count = 0;
      model_pc    = 32'h0;
      stale       = 1'b0;
      sb.delete();
    end else if (r) begin
      if (req_now) begin
        if (a) stale = 1'b0;
        else begin
          if (!stale) stale_addr = model_pc[7:0];
          stale = 1'b1;
        end
      end
      model_pc    = rpc;
      model_count = 0;
      sb.delete();
    end else begin
      pop_ok = d && (model_count > 0);
      if (req_now && a) begin
        if (stale) stale = 1'b0;
        else begin
          if (model_count == DEPTH) flagFail("push_at_full", "push at count 4", "no request when full");
          sb.push_back({model_pc, memWord(model_pc[7:0])});
          model_pc    = model_pc + 32'd1;
          model_count = model_count + 1;
        end
      end
      if (pop_ok) model_count = model_count - 1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rstd === 1'b0 && redirect === 1'b0 && deq === 1'b1 && ins_valid === 1'b1) begin
        if (sb.size() == 0) begin
          flagFail("sb_underflow", "valid head", "empty queue");
        end else begin
          mon_exp = sb.pop_front();
          checkVal("head_pc", ins_pc, mon_exp[63:32]);
          checkVal("head_ins", ins, mon_exp[31:0]);
          pops++;
        end
      end
    end
  end

  initial begin
    int pops0;
    int g;
    logic [31:0] rpc;

    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkVal("reset_req", 32'(imem_req), 32'h0);
    checkVal("reset_count", 32'(count), 32'h0);

    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 32'h0);
    checkVal("fill_count", 32'(count), 32'd4);
    checkVal("fill_req", 32'(imem_req), 32'h0);
    checkVal("fill_ins", ins, 32'd100);
    checkVal("fill_ins_pc", ins_pc, 32'h0);

    pops0 = pops;
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkVal("stream_rate", 32'(pops - pops0), 32'd20);

    applyStimulus(0, 0, 0, 1, 32'h40);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkVal("redir_flush_count", 32'(count), 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h0);
    for (g = 0; g < 10; g++) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      if (ins_valid === 1'b1) break;
    end
    if (g == 10) flagFail("redir_first_valid", "no valid", "valid within 10 cycles");
    checkVal("redir_ins_pc", ins_pc, 32'h40);
    checkVal("redir_ins", ins, 32'h40 + 32'd100);

    g = 0;
    while (model_count < 2 && g < 10) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      g++;
    end
    applyStimulus(0, 2, 1, 1, 32'hFFFF_FFFE);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkVal("redir_ack_count", 32'(count), 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkVal("deq_empty_count", 32'(count), 32'h0);
    checkVal("redir_ack_addr", 32'(imem_addr), 32'hFE);

    g = 0;
    while (model_count < 2 && g < 10) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      g++;
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkVal("pushpop_count", 32'(count), 32'd2);
    end

    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
      applyStimulus(0, 3, 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), rpc);
    end

    g = 0;
    while (model_count > 0 && g < 20) begin
      applyStimulus(0, 0, 1, 0, 32'h0);
      g++;
    end
    g = 0;
    while (model_count < 3 && g < 30) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      g++;
    end
    applyStimulus(1, 2, 0, 0, 32'h0);
    checkVal("pre_reset_count", 32'(count), 32'd3);
    checkVal("pre_reset_req", 32'(imem_req), 32'h1);
    applyStimulus(0, 2, 0, 0, 32'h0);
    checkVal("midreset_count", 32'(count), 32'h0);
    checkVal("midreset_req", 32'(imem_req), 32'h0);
    checkVal("midreset_valid", 32'(ins_valid), 32'h0);
    checkVal("midreset_ins", ins, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkVal("stray_ack_count", 32'(count), 32'h0);
    for (g = 0; g < 10; g++) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      if (ins_valid === 1'b1) break;
    end
    if (g == 10) flagFail("restart_valid", "no valid", "valid within 10 cycles");
    checkVal("restart_ins_pc", ins_pc, 32'h0);
    checkVal("restart_ins", ins, 32'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
